// File: rtl/mmio_uart_tx_pkg.sv
// Shared memory-map definitions: register offsets, STATUS bit positions, TX FSM encoding.
// The address decoder and the future UART receiver import these as well.
package mmio_defs;
  localparam logic [31:0] OFF_TXDATA = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam logic [31:0] OFF_CTRL   = 32'h8;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// Memory-map write port plus combinational read port between the memory stage and a peripheral.
interface mmio_uart_tx_if;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO; pointers wrap naturally, occupancy tracked in a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, control/overflow state, byte FIFO
// and the serialising FSM with its baud counter.
module mmio_uart_tx
  import mmio_defs::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy,
  output logic           fifo_full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e      state, state_nx;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           enable, overflow;
  logic           pop, fifo_empty, baud_done;
  logic [7:0]     fifo_dout;
  logic [AW:0]    fifo_count;
  logic [31:0]    wr_word, rd_word;
  logic           hit_txdata, hit_status, hit_ctrl;
  logic           unused_ok;

  assign wr_word    = {bus.wr_addr[31:2], 2'b00};
  assign rd_word    = {bus.rd_addr[31:2], 2'b00};
  assign hit_txdata = bus.wr_en && (wr_word == BASE_ADDR + OFF_TXDATA);
  assign hit_status = bus.wr_en && (wr_word == BASE_ADDR + OFF_STATUS);
  assign hit_ctrl   = bus.wr_en && (wr_word == BASE_ADDR + OFF_CTRL);
  assign unused_ok  = ^{bus.wr_data[31:8], bus.wr_addr[1:0], bus.rd_addr[1:0]};

  // Fullness is the registered count, so a push while full is refused even on a pop cycle.
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hit_txdata),
    .din   (bus.wr_data[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (hit_ctrl)                    enable   <= bus.wr_data[0];
      if (hit_status)                  overflow <= 1'b0;
      else if (hit_txdata && fifo_full) overflow <= 1'b1;
    end
  end

  assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE:  if (enable && !fifo_empty) begin
                 pop      = 1'b1;
                 state_nx = S_START;
               end
      S_START: if (baud_done) state_nx = S_DATA;
      S_DATA:  if (baud_done && bit_idx == 3'd7) state_nx = S_STOP;
      S_STOP:  if (baud_done) begin
                 // Chain straight into the next start bit so frames are contiguous.
                 if (enable && !fifo_empty) begin
                   pop      = 1'b1;
                   state_nx = S_START;
                 end else begin
                   state_nx = S_IDLE;
                 end
               end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nx;
      baud_cnt <= (state == S_IDLE || baud_done) ? '0 : baud_cnt + 1'b1;
      if (state == S_START)                bit_idx <= '0;
      else if (state == S_DATA && baud_done) bit_idx <= bit_idx + 1'b1;
      if (pop)                             shift <= fifo_dout;
      else if (state == S_DATA && baud_done) shift <= shift >> 1;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != S_IDLE) || !fifo_empty;

  always_comb begin
    bus.rd_data = '0;
    if (rd_word == BASE_ADDR + OFF_STATUS) begin
      bus.rd_data[ST_BUSY]             = busy;
      bus.rd_data[ST_FULL]             = fifo_full;
      bus.rd_data[ST_EMPTY]            = fifo_empty;
      bus.rd_data[ST_OVF]              = overflow;
      bus.rd_data[ST_CNT_LSB +: 8]     = 8'(fifo_count);
    end else if (rd_word == BASE_ADDR + OFF_CTRL) begin
      bus.rd_data[0] = enable;
    end
  end
endmodule
